// File: rtl/proc_tb_pkg.sv
// Shared types and default constants for the processor run monitor.
package proc_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int unsigned DEF_PC_W         = 64;
  localparam int unsigned DEF_DATA_W       = 64;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_RESET_CYCLES = 1;
  localparam int unsigned DEF_DRAIN_CYCLES = 1;
  localparam int unsigned DEF_TALLY_W      = 8;
  localparam logic [15:0] DEFAULT_TIMEOUT  = 16'hFF;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/proc_run_monitor.sv
// Run controller and result checker: resets the processor, waits for the end PC
// or watchdog, samples write-back data and keeps pass/run tallies.
module proc_run_monitor
  import proc_tb_pkg::*;
#(
  parameter int unsigned PC_W         = DEF_PC_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned TALLY_W      = DEF_TALLY_W
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    end_pc,
  input  logic [DATA_W-1:0]  expected,
  input  logic [CNT_W-1:0]   timeout,
  input  logic [PC_W-1:0]    currentpc,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               proc_resetl,
  output logic               busy,
  output logic               result_valid,
  output logic               pass,
  output logic               timed_out,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [TALLY_W-1:0] run_count,
  output logic [TALLY_W-1:0] pass_count,
  output logic               all_passed
);

  localparam int unsigned WAIT_MAX = max2(RESET_CYCLES, DRAIN_CYCLES);
  localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_e              state, state_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic [PC_W-1:0]     end_pc_q;
  logic [DATA_W-1:0]   expected_q;
  logic [CNT_W-1:0]    timeout_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                pass_d, timed_d, capture, done_entry;

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next state plus the values each registered output takes on this edge.
  always_comb begin
    state_d    = state;
    wait_d     = wait_cnt;
    cnt_d      = cycle_count;
    pass_d     = pass;
    timed_d    = timed_out;
    capture    = 1'b0;
    done_entry = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RESET;
          wait_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          timed_d = 1'b0;
          capture = 1'b1;
        end
      end
      ST_RESET: begin
        if (wait_cnt == WAIT_W'(RESET_CYCLES - 1)) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = cycle_count + CNT_W'(1);
        // End PC takes priority over a watchdog expiring in the same cycle.
        if (currentpc >= end_pc_q) begin
          state_d = (DRAIN_CYCLES == 0) ? ST_CHECK : ST_DRAIN;
          wait_d  = '0;
        end else if ((timeout_q != '0) && (cycle_count == timeout_q - CNT_W'(1))) begin
          state_d    = ST_DONE;
          timed_d    = 1'b1;
          pass_d     = 1'b0;
          done_entry = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (wait_cnt == WAIT_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_CHECK;
          wait_d  = '0;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      ST_CHECK: begin
        pass_d     = (wb_data == expected_q);
        state_d    = ST_DONE;
        done_entry = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wait_cnt     <= '0;
      end_pc_q     <= '0;
      expected_q   <= '0;
      timeout_q    <= '0;
      cycle_count  <= '0;
      pass         <= 1'b0;
      timed_out    <= 1'b0;
      result_valid <= 1'b0;
      proc_resetl  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      wait_cnt     <= wait_d;
      cycle_count  <= cnt_d;
      pass         <= pass_d;
      timed_out    <= timed_d;
      result_valid <= done_entry;
      proc_resetl  <= (state_d != ST_IDLE) && (state_d != ST_RESET);
      busy         <= (state_d == ST_RESET) || (state_d == ST_RUN) ||
                      (state_d == ST_DRAIN) || (state_d == ST_CHECK);
      if (capture) begin
        end_pc_q   <= end_pc;
        expected_q <= expected;
        timeout_q  <= timeout;
      end
    end
  end

  sat_counter #(.W(TALLY_W)) u_run_count (
    .clk   (CLK),
    .clr   (reset),
    .en    (done_entry),
    .count (run_count)
  );

  sat_counter #(.W(TALLY_W)) u_pass_count (
    .clk   (CLK),
    .clr   (reset),
    .en    (done_entry && pass_d),
    .count (pass_count)
  );

  assign all_passed = (run_count != '0) && (pass_count == run_count);

endmodule

// File: tb/tb_proc_run_monitor.sv
// Self-checking bench for proc_run_monitor with a toy PC-stepping processor model.
module tb_proc_run_monitor;
  import proc_tb_pkg::*;

  localparam int unsigned R = 2;
  localparam int unsigned D = 1;

  logic        CLK = 1'b0;
  logic        reset, start;
  logic [63:0] end_pc, expected, wb_data, currentpc;
  logic [15:0] timeout;
  logic        proc_resetl, busy, result_valid, pass, timed_out, all_passed;
  logic [15:0] cycle_count;
  logic [7:0]  run_count, pass_count;

  logic [63:0] step = 64'd4;
  int checks = 0;
  int failures = 0;
  int m_runs = 0;
  int m_pass = 0;

  always #5 CLK = ~CLK;

  // Processor stand-in: PC held at 0 under reset, then advances by step per cycle.
  initial currentpc = '0;
  always @(posedge CLK) currentpc <= proc_resetl ? currentpc + step : 64'd0;

  proc_run_monitor #(
    .PC_W(64), .DATA_W(64), .CNT_W(16),
    .RESET_CYCLES(R), .DRAIN_CYCLES(D), .TALLY_W(8)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .end_pc(end_pc),
    .expected(expected), .timeout(timeout), .currentpc(currentpc),
    .wb_data(wb_data), .proc_resetl(proc_resetl), .busy(busy),
    .result_valid(result_valid), .pass(pass), .timed_out(timed_out),
    .cycle_count(cycle_count), .run_count(run_count),
    .pass_count(pass_count), .all_passed(all_passed)
  );

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run; the expected outcome follows from the PC ramp 0, s, 2s, ...
  task automatic do_run(input longint unsigned e, input longint unsigned ex,
                        input longint unsigned wb, input longint unsigned t,
                        input longint unsigned s, input int poke);
    longint unsigned k, lat, exp_cc;
    bit timed, exp_pass;
    int n;
    if (e == 0)      k = 0;
    else if (s == 0) k = 64'd1 << 40;
    else             k = (e + s - 1) / s;
    timed    = (t != 0) && (k >= t);
    exp_pass = !timed && (wb == ex);
    exp_cc   = timed ? t : ((k + 1) & 64'hFFFF);
    lat      = timed ? (R + t) : (R + k + 2 + D);
    if (m_runs < 255) m_runs++;
    if (exp_pass && m_pass < 255) m_pass++;

    @(negedge CLK);
    end_pc = e; expected = ex; wb_data = wb; timeout = 16'(t); step = s;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 1;
    chk("launch_busy", busy, 1);
    chk("launch_resetl", proc_resetl, 0);
    while (!result_valid && n < 3000) begin
      @(negedge CLK);
      n++;
      start = (poke != 0) && (n == poke);
    end
    start = 1'b0;
    chk("latency", longint'(n), lat + 1);
    chk("pass", pass, exp_pass);
    chk("timed_out", timed_out, timed);
    chk("cycle_count", cycle_count, exp_cc);
    chk("run_count", run_count, m_runs);
    chk("pass_count", pass_count, m_pass);
    chk("all_passed", all_passed, (m_runs != 0) && (m_pass == m_runs));
    @(negedge CLK);
    chk("rv_pulse", result_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_resetl", proc_resetl, 1);
  endtask

  initial begin
    int seen;
    longint unsigned s, t, e, ex;
    reset = 1'b1; start = 1'b0; end_pc = '0; expected = '0; wb_data = '0; timeout = '0;
    repeat (3) @(negedge CLK);
    chk("rst_resetl", proc_resetl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timed", timed_out, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_runs", run_count, 0);
    chk("rst_passes", pass_count, 0);
    chk("rst_all", all_passed, 0);
    reset = 1'b0;

    do_run(64'h34, 12, 12, 64'(DEFAULT_TIMEOUT), 4, 0);
    do_run(64'h34, 12, 11, 64'(DEFAULT_TIMEOUT), 4, 0);
    do_run(64'h34, 12, 12, 64'(DEFAULT_TIMEOUT), 0, 0);
    do_run(76, 5, 5, 20, 4, R + 5);
    do_run(80, 5, 5, 20, 4, 0);
    do_run(0, 7, 7, 1, 0, 0);
    do_run(8, 7, 7, 1, 4, 0);
    do_run(40, 9, 9, 0, 4, 0);

    for (int i = 0; i < 25; i++) begin
      s = 64'($urandom_range(0, 3)) * 4;
      t = ($urandom_range(0, 3) == 0) ? 0 : 64'($urandom_range(1, 60));
      if (t == 0 && s == 0) s = 8;
      e  = 64'($urandom_range(0, 200));
      ex = {32'($urandom), 32'($urandom)};
      do_run(e, ex, ($urandom_range(0, 1) == 1) ? ex : ex ^ 64'h1, t, s, 0);
    end

    for (int i = 0; i < 300; i++) do_run(4, 3, 3, 10, 4, 0);
    chk("sat_runs", run_count, 255);
    chk("sat_passes", pass_count, 255);

    // Abort mid-run: everything returns to reset values, no result posted.
    @(negedge CLK);
    end_pc = 64'h1000; timeout = 16'hFF; step = 4; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (R + 6) @(negedge CLK);
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_resetl", proc_resetl, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_cc", cycle_count, 0);
    chk("abort_runs", run_count, 0);
    chk("abort_all", all_passed, 0);
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (result_valid || busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    m_runs = 0; m_pass = 0;
    do_run(64'h34, 12, 12, 64'(DEFAULT_TIMEOUT), 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
